// File: rtl/hazard_pkg.sv
// ----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the pipeline hazard / stall controller.
//   - state_t      : sequencing FSM states (S_RUN, S_HALTED)
//   - REG_ZERO     : architectural register $0, which never carries a hazard
//   - REG_ADDR_DEFAULT : default register-address width of the core
// ----------------------------------------------------------------------------
package hazard_pkg;

  localparam int REG_ADDR_DEFAULT = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // RUN is the normal operating state; HALTED is entered from HALT in WB
  // and only reset leaves it.
  typedef enum logic {
    S_RUN    = 1'b0,
    S_HALTED = 1'b1
  } state_t;

endpackage

// File: rtl/mdu_busy_tracker.sv
// ----------------------------------------------------------------------------
// mdu_busy_tracker
// Tracks the latency window of the multi-cycle MULT/DIV unit.
// A launch strobe loads the full latency; the counter then counts down and
// rests at zero. The unit is busy whenever the counter is non-zero.
// Parameters:
//   MDU_CYCLES  MDU latency in cycles (>= 2)
// Ports:
//   clk    in   core clock, rising edge
//   reset  in   asynchronous, active-low reset (clears the pending result)
//   start  in   one-cycle MDU launch strobe
//   busy   out  MDU result pending
// ----------------------------------------------------------------------------
module mdu_busy_tracker #(
  parameter int MDU_CYCLES = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy
);

  localparam int CW = $clog2(MDU_CYCLES + 1);

  logic [CW-1:0] cnt;

  // Launch loads the whole window; afterwards count down and saturate at 0.
  // A new launch is only ever granted once the counter has reached zero,
  // because the top stalls MDU instructions while busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= CW'(MDU_CYCLES);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_stall_ctrl
// Pipeline sequencing controller for the 5-stage MIPS core. It sits beside the
// forwarding network and stalls the front end for hazards forwarding cannot
// cover: load-use, branch/JR operands still in flight, and MULT/DIV unit busy.
// It also owns the HALT drain: once HALT reaches WB the front end is frozen and
// bubbles are fed into EX forever, letting EX/MEM/WB empty out.
//
// Optional feature (macro HAZARD_PERF_CNT_EN):
//   adds parameter CNT_W and output o_stall_cnt, a saturating count of cycles
//   with a hazard stall while running (HALTED cycles are not counted).
//
// Parameters:
//   REG_ADDR    register address width
//   MDU_CYCLES  MDU latency in cycles (>= 2)
//   CNT_W       perf-counter width (only with HAZARD_PERF_CNT_EN)
// Ports:
//   i_clk, i_reset                 clock / async active-low reset
//   i_instr_rs_D, i_instr_rt_D     source registers of the instr in ID
//   i_branch_D, i_jump_reg_D       ID holds BEQ/BNE or JR/JALR
//   i_mdu_start_D, i_mdu_read_D    ID holds MULT/DIV or MFHI/MFLO
//   i_halt_W                       HALT in WB
//   i_instr_rt_E, i_write_reg_E    rt and destination of the instr in EX
//   i_mem_read_E, i_reg_write_E    EX instr is a load / writes the RF
//   i_write_reg_M, i_mem_read_M    destination / load flag of the instr in MEM
//   o_stall_F, o_stall_D, o_flush_E  hold PC, hold IF/ID, bubble into ID/EX
//   o_mdu_start                    one-cycle MDU launch strobe
//   o_mdu_busy                     MDU result pending
//   o_halted                       core halted
//   o_stall_cnt                    hazard-stall cycle count (optional)
// ----------------------------------------------------------------------------
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR   = REG_ADDR_DEFAULT,
  parameter int MDU_CYCLES = 32
`ifdef HAZARD_PERF_CNT_EN
  ,
  parameter int CNT_W      = 16
`endif
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [REG_ADDR-1:0] i_instr_rs_D,
  input  logic [REG_ADDR-1:0] i_instr_rt_D,
  input  logic                i_branch_D,
  input  logic                i_jump_reg_D,
  input  logic                i_mdu_start_D,
  input  logic                i_mdu_read_D,
  input  logic                i_halt_W,
  input  logic [REG_ADDR-1:0] i_instr_rt_E,
  input  logic [REG_ADDR-1:0] i_write_reg_E,
  input  logic                i_mem_read_E,
  input  logic                i_reg_write_E,
  input  logic [REG_ADDR-1:0] i_write_reg_M,
  input  logic                i_mem_read_M,
  output logic                o_stall_F,
  output logic                o_stall_D,
  output logic                o_flush_E,
  output logic                o_mdu_start,
  output logic                o_mdu_busy,
  output logic                o_halted
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]    o_stall_cnt
`endif
);

  localparam logic [REG_ADDR-1:0] ZERO_REG = REG_ADDR'(REG_ZERO);

  state_t state;
  state_t state_next;

  logic lw_stall;
  logic br_ex_match;
  logic br_mem_match;
  logic br_stall;
  logic mdu_stall;
  logic hz;
  logic stall_all;
  logic mdu_busy;

  // Load-use: the loaded value is only available after MEM, so an ID consumer
  // of the load's rt must wait one cycle. $0 is never a real dependency.
  assign lw_stall = i_mem_read_E && (i_instr_rt_E != ZERO_REG) &&
                    ((i_instr_rt_E == i_instr_rs_D) || (i_instr_rt_E == i_instr_rt_D));

  // Branches and JR resolve in ID, so any operand still being computed in EX,
  // or still being loaded in MEM, cannot be forwarded in time.
  assign br_ex_match  = i_reg_write_E && (i_write_reg_E != ZERO_REG) &&
                        ((i_write_reg_E == i_instr_rs_D) || (i_write_reg_E == i_instr_rt_D));
  assign br_mem_match = i_mem_read_M && (i_write_reg_M != ZERO_REG) &&
                        ((i_write_reg_M == i_instr_rs_D) || (i_write_reg_M == i_instr_rt_D));
  assign br_stall     = (i_branch_D || i_jump_reg_D) && (br_ex_match || br_mem_match);

  // While the MDU is working, neither a new launch nor a HI/LO read may leave ID.
  assign mdu_stall = mdu_busy && (i_mdu_start_D || i_mdu_read_D);

  assign hz = lw_stall || br_stall || mdu_stall;

  // Sequencing FSM state register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state <= S_RUN;
    end else begin
      state <= state_next;
    end
  end

  // HALT in WB freezes the core; only reset leaves HALTED, and a further
  // HALT while halted changes nothing.
  always_comb begin
    state_next = state;
    case (state)
      S_RUN:    if (i_halt_W) state_next = S_HALTED;
      S_HALTED: state_next = S_HALTED;
      default:  state_next = S_RUN;
    endcase
  end

  // Outputs: every hazard and the halted state freeze IF/ID and bubble EX.
  // The MDU is launched only on the cycle its instruction actually leaves ID,
  // so a stalled MULT/DIV cannot launch twice.
  always_comb begin
    stall_all   = hz || (state == S_HALTED);
    o_stall_F   = stall_all;
    o_stall_D   = stall_all;
    o_flush_E   = stall_all;
    o_mdu_start = i_mdu_start_D && !stall_all;
    o_halted    = (state == S_HALTED);
  end

  mdu_busy_tracker #(
    .MDU_CYCLES(MDU_CYCLES)
  ) u_mdu_busy_tracker (
    .clk  (i_clk),
    .reset(i_reset),
    .start(o_mdu_start),
    .busy (mdu_busy)
  );

  assign o_mdu_busy = mdu_busy;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt;

  // Hazard-stall cycles while running; the halt drain is deliberately not
  // counted. The counter sticks at all-ones rather than wrapping.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      stall_cnt <= '0;
    end else if (hz && (state == S_RUN) && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign o_stall_cnt = stall_cnt;
`endif

endmodule
